// File: rtl/rv_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with a start/busy/done handshake.
// Each CALC cycle handles one multiplier bit (shift-add) or one quotient bit (restoring).
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply leaves CALC as soon as no multiplier
// bits remain, and a multiply by zero finishes straight from IDLE.
module rv_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0]  MostNeg = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    // Multiplicand for multiplies, divisor for divides.
    logic [XLEN-1:0]   a_q, a_d;
    // Remaining multiplier bits, shifted right one per step.
    logic [XLEN-1:0]   b_q, b_d;
    // Multiply: partial product. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_div, s1_signed, s2_signed, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;

    // Decode the requested operation and take operand magnitudes at acceptance.
    always_comb begin
        is_div    = funct3_i[2];
        s1_signed = is_div ? ~funct3_i[0] : (funct3_i[1] ^ funct3_i[0]);
        s2_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
        neg1      = s1_signed & src1_i[XLEN-1];
        neg2      = s2_signed & src2_i[XLEN-1];
        mag1      = neg1 ? ('0 - src1_i) : src1_i;
        mag2      = neg2 ? ('0 - src2_i) : src2_i;
        div_zero  = is_div && (src2_i == '0);
        div_ovf   = is_div && !funct3_i[0] && (src1_i == MostNeg) && (src2_i == '1);
    end

    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] prod_al, prod_fin;
    logic [XLEN-1:0]   qr, fin_res;
    logic              calc_done;

    // One datapath step and the sign-corrected final result.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, a_q};
`ifdef MULDIV_EARLY_OUT_EN
        // Unconsumed multiplier bits are all zero: align the partial product in one shift.
        prod_al   = acc_q >> (CntLast - cnt_q);
        calc_done = (cnt_q == CntLast) || (!op_q[2] && (b_q == '0));
`else
        prod_al   = acc_q;
        calc_done = (cnt_q == CntLast);
`endif
        prod_fin = neg_q ? ('0 - prod_al) : prod_al;
        qr       = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (op_q[2]) begin
            fin_res = neg_q ? ('0 - qr) : qr;
        end else if (op_q[1:0] == 2'b00) begin
            fin_res = prod_fin[XLEN-1:0];
        end else begin
            fin_res = prod_fin[2*XLEN-1:XLEN];
        end
    end

    // FSM next state and working-register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d  = funct3_i;
                    cnt_d = '0;
                    // Remainder takes the dividend's sign; everything else the xor.
                    neg_d = (is_div && funct3_i[1]) ? neg1 : (neg1 ^ neg2);
                    a_d   = is_div ? mag2 : mag1;
                    b_d   = mag2;
                    acc_d = is_div ? {{XLEN{1'b0}}, mag1} : '0;
                    if (div_zero) begin
                        res_d   = funct3_i[1] ? src1_i : '1;
                        state_d = StFin;
                    end else if (div_ovf) begin
                        res_d   = funct3_i[1] ? '0 : src1_i;
                        state_d = StFin;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (!is_div && (src2_i == '0)) begin
                        res_d   = '0;
                        state_d = StFin;
`endif
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (calc_done) begin
                    res_d   = fin_res;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                        b_d   = b_q >> 1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = (state_q == StCalc);
    assign done_o   = (state_q == StFin);
    assign result_o = res_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32): directed cases plus random operations,
// all checked cycle by cycle against an arithmetic reference model.
module tb_rv_muldiv_unit;

    logic        clk, rst_i, start_i;
    logic [2:0]  funct3_i;
    logic [31:0] src1_i, src2_i, result_o;
    logic        busy_o, done_o;

    rv_muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    bit          chk_en = 0;
    bit          pend = 0;
    int          cyc = 0;
    int          exp_lat = 0;
    logic [31:0] exp_res = '0;
    logic [31:0] held = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        logic [31:0] m;
        int          hi;
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[2]) begin
            m  = (f == 3'd1 && b[31]) ? -b : b;
            hi = -1;
            for (int i = 0; i < 32; i++) if (m[i]) hi = i;
            return (hi < 0) ? 1 : hi + 3;
        end
`else
        m  = '0;
        hi = 0;
`endif
        return 34;
    endfunction

    // Compare process: every cycle, check handshake and result against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (pend) begin
                check("done", {31'd0, done_o}, {31'd0, cyc == exp_lat});
                check("busy", {31'd0, busy_o}, {31'd0, (cyc >= 1) && (cyc < exp_lat)});
                if (cyc == exp_lat) begin
                    check("result", result_o, exp_res);
                    held = exp_res;
                    pend = 0;
                end else begin
                    check("hold", result_o, held);
                end
                cyc++;
            end else begin
                check("idle_done", {31'd0, done_o}, 32'd0);
                check("idle_busy", {31'd0, busy_o}, 32'd0);
                check("idle_result", result_o, held);
            end
        end
    end

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit has_lit, input logic [31:0] lit_res, input int lit_lat,
                         input bit poke);
        int k, bc;
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = f;
        src1_i   = a;
        src2_i   = b;
        exp_res  = model_res(f, a, b);
        exp_lat  = model_lat(f, a, b);
        cyc      = 0;
        pend     = 1;
        @(posedge clk); #1;
        start_i  = 1'b0;
        funct3_i = 3'($urandom);
        src1_i   = $urandom;
        src2_i   = $urandom;
        k  = 1;
        bc = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            if (busy_o) bc++;
            if (poke && k == 5) begin
                start_i  = 1'b1;
                funct3_i = 3'b100;
                src1_i   = $urandom;
                src2_i   = $urandom;
            end
            if (poke && k == 8) start_i = 1'b0;
            k++;
            if (k > 200) begin
                check("timeout", 32'd0, 32'd1);
                pend = 0;
                break;
            end
        end
        if (has_lit) begin
            check("lit_result", result_o, lit_res);
            if (lit_lat > 0) check("lit_latency", k, lit_lat);
            if (lit_lat > 1) check("lit_busy_cycles", bc, lit_lat - 1);
        end
    endtask

    int l_mul76, l_mul0, l_mul31;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; funct3_i = '0; src1_i = '0; src2_i = '0;
`ifdef MULDIV_EARLY_OUT_EN
        l_mul76 = 5; l_mul0 = 1; l_mul31 = 3;
`else
        l_mul76 = 34; l_mul0 = 34; l_mul31 = 34;
`endif
        #2 rst_i = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;

        do_op(3'd0, 32'd7, 32'd6, 1, 32'd42, l_mul76, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, -1, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, -1, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, -1, 0);
        do_op(3'd4, -32'sd7, 32'd2, 1, 32'hFFFF_FFFD, 34, 0);
        do_op(3'd6, -32'sd7, 32'd2, 1, 32'hFFFF_FFFF, 34, 0);
        do_op(3'd5, 32'd100, 32'd7, 1, 32'd14, 34, 0);
        do_op(3'd7, 32'd100, 32'd7, 1, 32'd2, 34, 0);
        do_op(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1, 0);
        do_op(3'd7, 32'd5, 32'd0, 1, 32'd5, 1, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1, 0);
        do_op(3'd0, 32'd123, 32'd0, 1, 32'd0, l_mul0, 0);
        do_op(3'd0, 32'd3, 32'd1, 1, 32'd3, l_mul31, 0);
        // Start pulses and operand changes while busy must be ignored.
        do_op(3'd0, 32'd1234, 32'd5678, 1, 32'd7006652, l_mul76 == 34 ? 34 : -1, 1);

        // Abort a divide with reset at its tenth cycle.
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = 3'd4; src1_i = 32'd1000; src2_i = 32'd3;
        exp_res = model_res(3'd4, 32'd1000, 32'd3);
        exp_lat = model_lat(3'd4, 32'd1000, 32'd3);
        cyc = 0; pend = 1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_i = 1'b0; pend = 0; held = '0;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 15);
                1: a = $urandom_range(0, 255);
                2: b = '0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(f, a, b, 0, '0, -1, 0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
